// File: rtl/load_store_unit.sv
// Memory stage: single-outstanding req/ack data-memory access with store lane steering,
// write-strobe generation and load extraction with sign/zero extension.
module load_store_unit #(
  parameter int REGISTER_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      is_store,
  input  logic [2:0]                funct3,
  input  logic [REGISTER_WIDTH-1:0] address,
  input  logic [REGISTER_WIDTH-1:0] store_data,
  input  logic [4:0]                rd_in,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [REGISTER_WIDTH-1:0] mem_addr,
  output logic [REGISTER_WIDTH-1:0] mem_wdata,
  output logic [3:0]                mem_wstrb,
  input  logic                      mem_ack,
  input  logic [REGISTER_WIDTH-1:0] mem_rdata,
  output logic                      done,
  output logic                      wb_we,
  output logic [4:0]                wb_rd,
  output logic [REGISTER_WIDTH-1:0] wb_data,
  output logic                      fault
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t                      state, state_next;
  logic                        is_store_q;
  logic [2:0]                  funct3_q;
  logic [1:0]                  lane_q;
  logic                        fault_q;

  logic                        accept;
  logic                        legal_funct3;
  logic                        aligned;
  logic                        req_ok;
  logic [REGISTER_WIDTH-1:0]   wdata_next;
  logic [3:0]                  wstrb_next;
  logic [7:0]                  byte_sel;
  logic [15:0]                 half_sel;
  logic [REGISTER_WIDTH-1:0]   load_value;

  assign accept    = (state == IDLE) && req_valid;
  assign req_ready = (state == IDLE);
  assign mem_req   = (state == MEM);
  assign mem_we    = mem_req && is_store_q;
  assign done      = (state == RESP);
  assign fault     = done && fault_q;
  assign wb_we     = done && !fault_q && !is_store_q && (wb_rd != 5'd0);

  // Legality is judged on the live request fields, in the cycle it is accepted.
  always_comb begin
    if (is_store) legal_funct3 = funct3 inside {3'b000, 3'b001, 3'b010};
    else          legal_funct3 = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (funct3[1:0])
      2'b01:   aligned = ~address[0];
      2'b10:   aligned = (address[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    req_ok = legal_funct3 && aligned;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    wdata_next = '0;
    wstrb_next = 4'b0000;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wdata_next = {4{store_data[7:0]}};
          wstrb_next = 4'b0001 << address[1:0];
        end
        2'b01: begin
          wdata_next = {2{store_data[15:0]}};
          wstrb_next = 4'b0011 << address[1:0];
        end
        2'b10: begin
          wdata_next = store_data;
          wstrb_next = 4'b1111;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_value = {{(REGISTER_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_value = {{(REGISTER_WIDTH-16){half_sel[15]}}, half_sel};
      3'b100:  load_value = {{(REGISTER_WIDTH-8){1'b0}}, byte_sel};
      3'b101:  load_value = {{(REGISTER_WIDTH-16){1'b0}}, half_sel};
      default: load_value = mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = req_ok ? MEM : RESP;
      MEM:     if (mem_ack)   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      fault_q    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= 4'b0000;
      wb_rd      <= 5'd0;
      wb_data    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        is_store_q <= is_store;
        funct3_q   <= funct3;
        lane_q     <= address[1:0];
        fault_q    <= ~req_ok;
        wb_rd      <= rd_in;
        wb_data    <= '0;
        mem_addr   <= {address[REGISTER_WIDTH-1:2], 2'b00};
        mem_wdata  <= req_ok ? wdata_next : '0;
        mem_wstrb  <= req_ok ? wstrb_next : 4'b0000;
      end
      // Store and fault responses keep the zero written at accept time.
      if ((state == MEM) && mem_ack && !is_store_q) wb_data <= load_value;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, randomized transactions
// against a byte-level reference model, and multi-cycle corner-case sequences.
module tb_load_store_unit;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [3:0]  delay;
  } req_t;

  typedef struct packed {
    logic        fault;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wb_we;
    logic [31:0] wb_data;
  } exp_t;

  typedef struct {
    req_t req;
    exp_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.REGISTER_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .address(address), .store_data(store_data),
    .rd_in(rd_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .done(done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic req_t mkreq(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rdat,
                                 input logic [4:0] rd, input logic [3:0] dly);
    req_t r;
    r.is_store = st; r.funct3 = f3; r.address = a; r.store_data = sd;
    r.rdata = rdat; r.rd = rd; r.delay = dly;
    return r;
  endfunction

  function automatic exp_t mkexp(input logic flt, input logic [31:0] a, input logic we,
                                 input logic [31:0] wd, input logic [3:0] ws,
                                 input logic wbwe, input logic [31:0] wbd);
    exp_t e;
    e.fault = flt; e.addr = a; e.we = we; e.wdata = wd; e.wstrb = ws;
    e.wb_we = wbwe; e.wb_data = wbd;
    return e;
  endfunction

  // Reference model: treats memory as four byte lanes and an access as `size` bytes at `off`.
  function automatic exp_t model(input req_t r);
    exp_t e;
    int size;
    int off;
    bit legal;
    logic [31:0] v;
    e = '0;
    size = 1 << r.funct3[1:0];
    off = int'(r.address[1:0]);
    if (r.is_store) legal = (r.funct3 <= 3'd2);
    else            legal = (r.funct3 <= 3'd2) || (r.funct3 == 3'd4) || (r.funct3 == 3'd5);
    if (legal && ((off % size) != 0)) legal = 1'b0;
    e.fault = !legal;
    if (!legal) return e;
    e.addr = r.address & 32'hFFFF_FFFC;
    e.we = r.is_store;
    if (r.is_store) begin
      for (int i = 0; i < 4; i++) begin
        e.wdata[8*i +: 8] = r.store_data[8*(i % size) +: 8];
        if (i >= off && i < off + size) e.wstrb[i] = 1'b1;
      end
    end else begin
      v = '0;
      for (int j = 0; j < size; j++) v[8*j +: 8] = r.rdata[8*(off+j) +: 8];
      if (!r.funct3[2] && size < 4 && v[8*size-1]) begin
        for (int b = 8*size; b < 32; b++) v[b] = 1'b1;
      end
      e.wb_data = v;
      e.wb_we = (r.rd != 5'd0);
    end
    return e;
  endfunction

  task automatic idle_inputs();
    req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000; address = '0;
    store_data = '0; rd_in = 5'd0; mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic drive_req(input req_t r);
    is_store = r.is_store; funct3 = r.funct3; address = r.address;
    store_data = r.store_data; rd_in = r.rd; req_valid = 1'b1;
  endtask

  // Runs one transaction starting from IDLE at posedge+1; acks `delay` cycles after mem_req rises.
  task automatic run_txn(input req_t r, input exp_t e, input string tag);
    int done_cyc = -1;
    int req_start = -1;
    bit stable = 1'b1;
    logic [31:0] a_cap = '0, wd_cap = '0;
    logic [3:0]  ws_cap = '0;
    logic        we_cap = 1'b0;
    logic        f_cap = 1'b0, wbwe_cap = 1'b0, req_at_done = 1'b0, rdy_at_done = 1'b0;
    logic [4:0]  rd_cap = '0;
    logic [31:0] wbd_cap = '0;
    check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    drive_req(r);
    @(posedge clk); #1;
    req_valid = 1'b0;
    address = $urandom; store_data = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
    for (int cyc = 1; cyc <= 24; cyc++) begin
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (done) begin
        done_cyc = cyc; f_cap = fault; wbwe_cap = wb_we; rd_cap = wb_rd; wbd_cap = wb_data;
        req_at_done = mem_req; rdy_at_done = req_ready;
        break;
      end
      if (mem_req) begin
        if (req_start < 0) begin
          req_start = cyc; a_cap = mem_addr; wd_cap = mem_wdata; ws_cap = mem_wstrb; we_cap = mem_we;
        end else if (mem_addr !== a_cap || mem_wdata !== wd_cap || mem_wstrb !== ws_cap ||
                     mem_we !== we_cap) begin
          stable = 1'b0;
        end
        if (req_ready) stable = 1'b0;
        if (cyc - req_start == int'(r.delay)) begin
          mem_ack = 1'b1;
          mem_rdata = r.rdata;
        end
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    if (done_cyc < 0) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_done_cycle"}, 32'(done_cyc), e.fault ? 32'd1 : 32'(int'(r.delay) + 2));
      check({tag, "_fault"}, 32'(f_cap), 32'(e.fault));
      check({tag, "_wb_we"}, 32'(wbwe_cap), 32'(e.wb_we));
      check({tag, "_wb_data"}, wbd_cap, e.wb_data);
      if (e.wb_we) check({tag, "_wb_rd"}, 32'(rd_cap), 32'(r.rd));
      check({tag, "_req_at_done"}, 32'(req_at_done), 32'd0);
      check({tag, "_ready_at_done"}, 32'(rdy_at_done), 32'd0);
      if (e.fault) begin
        check({tag, "_no_mem_req"}, 32'(req_start), 32'hFFFF_FFFF);
      end else begin
        check({tag, "_req_start"}, 32'(req_start), 32'd1);
        check({tag, "_stable"}, 32'(stable), 32'd1);
        check({tag, "_mem_addr"}, a_cap, e.addr);
        check({tag, "_mem_we"}, 32'(we_cap), 32'(e.we));
        check({tag, "_mem_wstrb"}, 32'(ws_cap), 32'(e.wstrb));
        if (e.we) check({tag, "_mem_wdata"}, wd_cap, e.wdata);
      end
    end
    @(posedge clk); #1;
    check({tag, "_done_single"}, 32'(done), 32'd0);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_wb_we"}, 32'(wb_we), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    check({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    check({tag, "_wb_data"}, wb_data, 32'd0);
  endtask

  vec_t vecs[13];

  initial begin
    req_t rq;
    req_t b2b[$];
    exp_t exp_q[$];
    int idx;
    int dones;
    int extra;
    bit ready_bad;

    vecs[0]  = '{mkreq(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 4'd3),
                 mkexp(0, 32'h100, 0, 32'h0, 4'b0000, 1, 32'hDEADBEEF)};
    vecs[1]  = '{mkreq(0, 3'b000, 32'h103, 32'h0, 32'h80FF0011, 5'd7, 4'd1),
                 mkexp(0, 32'h100, 0, 32'h0, 4'b0000, 1, 32'hFFFFFF80)};
    vecs[2]  = '{mkreq(0, 3'b100, 32'h103, 32'h0, 32'h80FF0011, 5'd7, 4'd0),
                 mkexp(0, 32'h100, 0, 32'h0, 4'b0000, 1, 32'h00000080)};
    vecs[3]  = '{mkreq(1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 5'd9, 4'd0),
                 mkexp(0, 32'h200, 1, 32'hABCDABCD, 4'b1100, 0, 32'h0)};
    vecs[4]  = '{mkreq(0, 3'b010, 32'h101, 32'h0, 32'h0, 5'd3, 4'd0),
                 mkexp(1, 32'h0, 0, 32'h0, 4'b0000, 0, 32'h0)};
    vecs[5]  = '{mkreq(0, 3'b001, 32'h003, 32'h0, 32'h0, 5'd3, 4'd0),
                 mkexp(1, 32'h0, 0, 32'h0, 4'b0000, 0, 32'h0)};
    vecs[6]  = '{mkreq(0, 3'b011, 32'h000, 32'h0, 32'h0, 5'd3, 4'd0),
                 mkexp(1, 32'h0, 0, 32'h0, 4'b0000, 0, 32'h0)};
    vecs[7]  = '{mkreq(1, 3'b100, 32'h000, 32'h55, 32'h0, 5'd3, 4'd0),
                 mkexp(1, 32'h0, 0, 32'h0, 4'b0000, 0, 32'h0)};
    vecs[8]  = '{mkreq(0, 3'b001, 32'h102, 32'h0, 32'h80FF0011, 5'd0, 4'd2),
                 mkexp(0, 32'h100, 0, 32'h0, 4'b0000, 0, 32'hFFFF80FF)};
    vecs[9]  = '{mkreq(0, 3'b101, 32'h102, 32'h0, 32'h80FF0011, 5'd31, 4'd1),
                 mkexp(0, 32'h100, 0, 32'h0, 4'b0000, 1, 32'h000080FF)};
    vecs[10] = '{mkreq(1, 3'b000, 32'h101, 32'h000000A7, 32'h0, 5'd1, 4'd2),
                 mkexp(0, 32'h100, 1, 32'hA7A7A7A7, 4'b0010, 0, 32'h0)};
    vecs[11] = '{mkreq(1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0, 5'd1, 4'd0),
                 mkexp(0, 32'h10C, 1, 32'hCAFEF00D, 4'b1111, 0, 32'h0)};
    vecs[12] = '{mkreq(1, 3'b011, 32'h108, 32'h1, 32'h0, 5'd2, 4'd0),
                 mkexp(1, 32'h0, 0, 32'h0, 4'b0000, 0, 32'h0)};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_txn(vecs[i].req, vecs[i].exp, $sformatf("vec%0d", i));

    // mem_ack while idle must not start or complete anything
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("stray_ack_done", 32'(done), 32'd0);
    check("stray_ack_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    check("stray_ack_done2", 32'(done), 32'd0);

    for (int i = 0; i < 300; i++) begin
      rq = mkreq(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                 5'($urandom), 4'($urandom_range(0, 3)));
      run_txn(rq, model(rq), $sformatf("rnd%0d", i));
    end

    // Back-to-back requests with req_valid held high; memory acks in the same cycle.
    b2b.push_back(mkreq(0, 3'b010, 32'h40, 32'h0, 32'h0, 5'd1, 4'd0));
    b2b.push_back(mkreq(0, 3'b010, 32'h44, 32'h0, 32'h0, 5'd2, 4'd0));
    b2b.push_back(mkreq(0, 3'b010, 32'h41, 32'h0, 32'h0, 5'd3, 4'd0));
    b2b.push_back(mkreq(1, 3'b010, 32'h48, 32'h77, 32'h0, 5'd4, 4'd0));
    b2b.push_back(mkreq(0, 3'b100, 32'h4A, 32'h0, 32'h0, 5'd5, 4'd0));
    foreach (b2b[i]) b2b[i].rdata = {b2b[i].address[31:2], 2'b00} ^ 32'h5A5A_0000;
    idx = 0; dones = 0; ready_bad = 1'b0;
    drive_req(b2b[0]);
    for (int cyc = 0; cyc < 60 && dones < b2b.size(); cyc++) begin
      bit accepted;
      mem_ack = mem_req;
      mem_rdata = mem_addr ^ 32'h5A5A_0000;
      if ((mem_req || done) && req_ready) ready_bad = 1'b1;
      if (done) begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("b2b%0d_fault", dones), 32'(fault), 32'(e.fault));
        check($sformatf("b2b%0d_wb_we", dones), 32'(wb_we), 32'(e.wb_we));
        check($sformatf("b2b%0d_wb_data", dones), wb_data, e.wb_data);
        check($sformatf("b2b%0d_wb_rd", dones), 32'(wb_rd), 32'(b2b[dones].rd));
        dones++;
      end
      accepted = req_ready && req_valid;
      if (accepted) exp_q.push_back(model(b2b[idx]));
      @(posedge clk); #1;
      if (accepted) begin
        idx++;
        if (idx < b2b.size()) drive_req(b2b[idx]);
        else req_valid = 1'b0;
      end
    end
    mem_ack = 1'b0;
    check("b2b_done_count", 32'(dones), 32'(b2b.size()));
    check("b2b_ready_low_busy", 32'(ready_bad), 32'd0);
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("b2b_no_extra_done", 32'(extra), 32'd0);

    // Reset lands in MEM together with mem_ack: reset wins, no done follows.
    drive_req(mkreq(0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd6, 4'd0));
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mem_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ack = 1'b0;
    check_reset_values("rst_mid");
    extra = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || mem_req) extra++;
    end
    check("rst_mid_no_done", 32'(extra), 32'd0);

    // Unit still works after the mid-transaction reset.
    rq = mkreq(0, 3'b001, 32'h306, 32'h0, 32'h8001_7FFF, 5'd12, 4'd1);
    run_txn(rq, model(rq), "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
